decoder_nto2n_seq: RTL and testbench



---
 rtl/decoder_nto2n_seq.sv | 108 ++++++++++
 tb/tb_decoder_nto2n_seq.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/decoder_nto2n_seq.sv
// Registered binary-to-one-hot decoder with valid/ready on both sides,
// plus a self-running scan mode that steps through every code.
//
// state  | meaning
// IDLE   | disabled; out cleared, nothing presented
// DIRECT | decodes accepted din codes, one word in flight
// SCAN   | walks code 0..OUT_W-1, one step per SCAN_DIV accepted cycles
module decoder_nto2n_seq #(
    parameter  int IN_W     = 3,
    parameter  int SCAN_DIV = 10,
    localparam int OUT_W    = 2**IN_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  din,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out,
    output logic [IN_W-1:0]  code,
    output logic             wrap
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t          state;
    logic [DIV_W-1:0] div;
    logic [IN_W-1:0] code_next;
    logic            slot_free;
    logic            accept;

    // A pending word blocks both new accepts and a mode change.
    assign slot_free = !out_valid || out_ready;
    assign in_ready  = (state == DIRECT) && en && !mode && slot_free;
    assign accept    = in_valid && in_ready;
    assign code_next = code + 1'b1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            code      <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            div       <= '0;
        end else if (!en) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
            wrap      <= 1'b0;
            div       <= '0;
        end else begin
            wrap <= 1'b0;
            case (state)
                IDLE: begin
                    if (mode) begin
                        state     <= SCAN;
                        code      <= '0;
                        out       <= OUT_W'(1);
                        out_valid <= 1'b1;
                        div       <= '0;
                    end else begin
                        state <= DIRECT;
                    end
                end
                DIRECT: begin
                    if (mode && slot_free) begin
                        state     <= SCAN;
                        code      <= '0;
                        out       <= OUT_W'(1);
                        out_valid <= 1'b1;
                        div       <= '0;
                    end else if (accept) begin
                        out       <= OUT_W'(1) << din;
                        code      <= din;
                        out_valid <= 1'b1;
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!mode && slot_free) begin
                        state     <= DIRECT;
                        out_valid <= 1'b0;
                    end else if (out_ready) begin
                        // code_next wraps naturally at OUT_W since it is IN_W bits wide
                        if (div == DIV_LAST) begin
                            div  <= '0;
                            code <= code_next;
                            out  <= OUT_W'(1) << code_next;
                            wrap <= (code == IN_W'(OUT_W - 1));
                        end else begin
                            div <= div + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
// Self-checking bench: three decoder widths driven in lockstep against an
// arithmetic reference model (scan code derived from accepted-cycle count).
module tb_decoder_nto2n_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, en, mode, in_valid, out_ready;
    logic [31:0] raw_din;
    logic [2:0]  din_a;
    logic [4:0]  din_b;
    logic [0:0]  din_c;

    logic        rdy_a, rdy_b, rdy_c;
    logic        ov_a, ov_b, ov_c;
    logic        wr_a, wr_b, wr_c;
    logic [7:0]  out_a;
    logic [31:0] out_b;
    logic [1:0]  out_c;
    logic [2:0]  code_a;
    logic [4:0]  code_b;
    logic [0:0]  code_c;

    decoder_nto2n_seq #(.IN_W(3), .SCAN_DIV(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_a), .din(din_a), .out_valid(ov_a), .out_ready(out_ready),
        .out(out_a), .code(code_a), .wrap(wr_a));

    decoder_nto2n_seq #(.IN_W(5), .SCAN_DIV(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_b), .din(din_b), .out_valid(ov_b), .out_ready(out_ready),
        .out(out_b), .code(code_b), .wrap(wr_b));

    decoder_nto2n_seq #(.IN_W(1), .SCAN_DIV(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(rdy_c), .din(din_c), .out_valid(ov_c), .out_ready(out_ready),
        .out(out_c), .code(code_c), .wrap(wr_c));

    logic [31:0] g_out[3];
    logic [31:0] g_code[3];
    logic        g_v[3];
    logic        g_w[3];
    logic        g_rdy[3];

    assign g_out[0]  = 32'(out_a);
    assign g_out[1]  = out_b;
    assign g_out[2]  = 32'(out_c);
    assign g_code[0] = 32'(code_a);
    assign g_code[1] = 32'(code_b);
    assign g_code[2] = 32'(code_c);
    assign g_v[0]    = ov_a;
    assign g_v[1]    = ov_b;
    assign g_v[2]    = ov_c;
    assign g_w[0]    = wr_a;
    assign g_w[1]    = wr_b;
    assign g_w[2]    = wr_c;
    assign g_rdy[0]  = rdy_a;
    assign g_rdy[1]  = rdy_b;
    assign g_rdy[2]  = rdy_c;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 idle, 1 direct, 2 scan; mn counts accepted scan cycles.
    int          ow[3] = '{8, 32, 2};
    int          dv[3] = '{2, 1, 3};
    int          ms[3];
    int          mn[3];
    int          mcode[3];
    logic        mv[3];
    logic        mw[3];
    logic [31:0] mout[3];
    bit          primed = 1'b0;

    function automatic logic m_ready(input int i);
        return (ms[i] == 1) && en && !mode && (!mv[i] || out_ready);
    endfunction

    task automatic enter_scan(input int i);
        ms[i] = 2; mn[i] = 0; mcode[i] = 0; mout[i] = 32'd1; mv[i] = 1'b1;
    endtask

    task automatic tick();
        din_a = raw_din[2:0];
        din_b = raw_din[4:0];
        din_c = raw_din[0:0];
        #1;
        for (int i = 0; i < 3; i++) begin
            logic rdy;
            int   d;
            rdy = m_ready(i);
            d   = int'(raw_din & 32'(ow[i] - 1));
            if (primed) check($sformatf("in_ready[%0d]", i), 32'(g_rdy[i]), 32'(rdy));
            if (!rst_n) begin
                ms[i] = 0; mv[i] = 0; mout[i] = 0; mcode[i] = 0; mw[i] = 0; mn[i] = 0;
            end else if (!en) begin
                ms[i] = 0; mv[i] = 0; mout[i] = 0; mw[i] = 0;
            end else begin
                mw[i] = 0;
                if (ms[i] == 0) begin
                    if (mode) enter_scan(i);
                    else ms[i] = 1;
                end else if (ms[i] == 1) begin
                    if (mode && (!mv[i] || out_ready)) enter_scan(i);
                    else if (in_valid && rdy) begin
                        mout[i] = 32'd1 << d; mcode[i] = d; mv[i] = 1'b1;
                    end else if (mv[i] && out_ready) mv[i] = 1'b0;
                end else begin
                    if (!mode && out_ready) begin
                        ms[i] = 1; mv[i] = 1'b0;
                    end else if (out_ready) begin
                        mn[i]++;
                        if (mn[i] % dv[i] == 0) begin
                            mcode[i] = (mn[i] / dv[i]) % ow[i];
                            mout[i]  = 32'd1 << mcode[i];
                            mw[i]    = (mcode[i] == 0);
                        end
                    end
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        primed = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("out[%0d]", i),       g_out[i],          mout[i]);
            check($sformatf("code[%0d]", i),      g_code[i],         32'(mcode[i]));
            check($sformatf("out_valid[%0d]", i), 32'(g_v[i]),       32'(mv[i]));
            check($sformatf("wrap[%0d]", i),      32'(g_w[i]),       32'(mw[i]));
        end
    endtask

    initial begin
        rst_n = 0; en = 0; mode = 0; in_valid = 0; out_ready = 0; raw_din = 0;
        repeat (3) tick();

        // direct sweep, full throughput
        rst_n = 1; en = 1; out_ready = 1; in_valid = 1;
        for (int v = 0; v < 34; v++) begin
            raw_din = 32'(v);
            tick();
        end

        // backpressure
        raw_din = 5; tick();
        out_ready = 0; raw_din = 2; repeat (3) tick();
        out_ready = 1; tick(); tick();
        in_valid = 0; tick();

        // scan with a mid-scan stall
        mode = 1; repeat (40) tick();
        out_ready = 0; repeat (3) tick();
        out_ready = 1; repeat (30) tick();

        // enable drop and reset mid-scan
        en = 0; tick();
        en = 1; repeat (12) tick();
        rst_n = 0; tick();
        rst_n = 1; repeat (5) tick();

        // mode switch while stalled
        mode = 0; tick(); tick();
        in_valid = 1; raw_din = 6; tick();
        in_valid = 0; out_ready = 0; mode = 1; repeat (3) tick();
        out_ready = 1; repeat (4) tick();

        // randomized traffic
        repeat (3000) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            en        = ($urandom_range(0, 49) != 0);
            if ($urandom_range(0, 29) == 0) mode = ~mode;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            raw_din   = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
